// File: rtl/snoop_bus_ctrl_pkg.sv
// Shared definitions for the L1 snoop bus: snoop codes, line states,
// controller states and code classification helpers.
package snoop_bus_ctrl_pkg;

    typedef enum logic [2:0] {
        SP_NONE    = 3'b000,
        SP_RD_MISS = 3'b001,
        SP_WR_MISS = 3'b010,
        SP_INVAL   = 3'b011,
        SP_WR_BACK = 3'b100
    } snoop_code_e;

    typedef enum logic [1:0] {
        INVALID     = 2'b00,
        SHARED      = 2'b01,
        OWNED_CLEAN = 2'b10,
        OWNED_DIRTY = 2'b11
    } line_state_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BCAST = 2'b01,
        ST_DONE  = 2'b10
    } ctrl_state_e;

    function automatic logic sp_is_valid(input logic [2:0] code);
        return (code != SP_NONE) && (code <= SP_WR_BACK);
    endfunction

    function automatic logic sp_is_illegal(input logic [2:0] code);
        return code > SP_WR_BACK;
    endfunction

endpackage

// File: rtl/snoop_bus_ctrl_if.sv
// Snoop bus between the four L1 caches (master) and the snoop controller (slave).
interface snoop_bus_ctrl_if #(
    parameter int ADDR_W = 24
);
    logic [2:0]        sp_req_0, sp_req_1, sp_req_2, sp_req_3;
    logic [ADDR_W-1:0] addr_req_0, addr_req_1, addr_req_2, addr_req_3;
    logic              owned_0, owned_1, owned_2, owned_3;
    logic              shared_0, shared_1, shared_2, shared_3;

    logic [2:0]        sp_out;
    logic [ADDR_W-1:0] addr_sp_out;
    logic [1:0]        sp_src;
    logic [1:0]        share_num;
    logic              owner_hit;
    logic [1:0]        owner_id;
    logic [3:0]        grant;
    logic              busy;
    logic              err;

    modport slave (
        input  sp_req_0, sp_req_1, sp_req_2, sp_req_3,
        input  addr_req_0, addr_req_1, addr_req_2, addr_req_3,
        input  owned_0, owned_1, owned_2, owned_3,
        input  shared_0, shared_1, shared_2, shared_3,
        output sp_out, addr_sp_out, sp_src, share_num,
        output owner_hit, owner_id, grant, busy, err
    );

    modport master (
        output sp_req_0, sp_req_1, sp_req_2, sp_req_3,
        output addr_req_0, addr_req_1, addr_req_2, addr_req_3,
        output owned_0, owned_1, owned_2, owned_3,
        output shared_0, shared_1, shared_2, shared_3,
        input  sp_out, addr_sp_out, sp_src, share_num,
        input  owner_hit, owner_id, grant, busy, err
    );
endinterface

// File: rtl/snoop_bus_ctrl_rr_pick4.sv
// Combinational 4-way round-robin picker: scans rr_ptr+1, +2, +3, rr_ptr.
module rr_pick4 (
    input  logic [3:0] valid,
    input  logic [1:0] rr_ptr,
    output logic       found,
    output logic [1:0] winner
);
    logic [1:0] idx;

    always_comb begin
        found  = '0;
        winner = '0;
        idx    = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && valid[idx]) begin
                found  = '1;
                winner = idx;
            end
        end
    end
endmodule

// File: rtl/snoop_bus_ctrl.sv
// Round-robin snoop bus controller: grants one L1 request at a time, broadcasts
// it, then collects owned/shared replies from the other three caches.
module snoop_bus_ctrl
    import snoop_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int RESP_WAIT = 2
) (
    input  logic            clk,
    input  logic            reset,
    snoop_bus_ctrl_if.slave bus
);
    localparam int CNT_W = (RESP_WAIT > 2) ? $clog2(RESP_WAIT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RESP_WAIT - 1);

    ctrl_state_e       state;
    logic [1:0]        rr_ptr;
    logic [CNT_W-1:0]  wait_cnt;

    logic [2:0]        sp_out_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        sp_src_q, share_num_q, owner_id_q;
    logic              owner_hit_q, busy_q, err_q;
    logic [3:0]        grant_q;

    logic [2:0]        req  [4];
    logic [ADDR_W-1:0] areq [4];
    logic [3:0]        valid_mask, self_mask, owned_oth, shared_oth;
    logic              illegal_seen, found, multi_own;
    logic [1:0]        winner, share_cnt, owner_pick;

    assign req  = '{bus.sp_req_0, bus.sp_req_1, bus.sp_req_2, bus.sp_req_3};
    assign areq = '{bus.addr_req_0, bus.addr_req_1, bus.addr_req_2, bus.addr_req_3};

    // The current requester's own reply is never counted.
    assign self_mask  = 4'b0001 << sp_src_q;
    assign owned_oth  = {bus.owned_3, bus.owned_2, bus.owned_1, bus.owned_0} & ~self_mask;
    assign shared_oth = {bus.shared_3, bus.shared_2, bus.shared_1, bus.shared_0} & ~self_mask;
    assign multi_own  = (owned_oth & (owned_oth - 4'd1)) != '0;

    always_comb begin
        valid_mask   = '0;
        illegal_seen = '0;
        share_cnt    = '0;
        owner_pick   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            valid_mask[i] = sp_is_valid(req[i]);
            illegal_seen  = illegal_seen | sp_is_illegal(req[i]);
            share_cnt     = share_cnt + 2'(shared_oth[i]);
            if (owned_oth[3-i]) owner_pick = 2'(3 - i);
        end
    end

    rr_pick4 u_pick (
        .valid  (valid_mask),
        .rr_ptr (rr_ptr),
        .found  (found),
        .winner (winner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            rr_ptr      <= 2'd3;
            wait_cnt    <= '0;
            sp_out_q    <= SP_NONE;
            addr_q      <= '0;
            sp_src_q    <= '0;
            share_num_q <= '0;
            owner_hit_q <= '0;
            owner_id_q  <= '0;
            grant_q     <= '0;
            busy_q      <= '0;
            err_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (illegal_seen) err_q <= '1;
                    if (found) begin
                        sp_out_q <= req[winner];
                        addr_q   <= areq[winner];
                        sp_src_q <= winner;
                        busy_q   <= '1;
                        wait_cnt <= (req[winner] == SP_WR_BACK) ? '0 : WAIT_LOAD;
                        state    <= ST_BCAST;
                    end
                end
                ST_BCAST: begin
                    if (wait_cnt == '0) begin
                        // Write-backs carry no snoop response.
                        if (sp_out_q == SP_WR_BACK) begin
                            share_num_q <= '0;
                            owner_hit_q <= '0;
                        end else begin
                            share_num_q <= share_cnt;
                            owner_hit_q <= |owned_oth;
                            owner_id_q  <= owner_pick;
                            if (multi_own) err_q <= '1;
                        end
                        grant_q  <= self_mask;
                        sp_out_q <= SP_NONE;
                        rr_ptr   <= sp_src_q;
                        state    <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    grant_q <= '0;
                    busy_q  <= '0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sp_out      = sp_out_q;
    assign bus.addr_sp_out = addr_q;
    assign bus.sp_src      = sp_src_q;
    assign bus.share_num   = share_num_q;
    assign bus.owner_hit   = owner_hit_q;
    assign bus.owner_id    = owner_id_q;
    assign bus.grant       = grant_q;
    assign bus.busy        = busy_q;
    assign bus.err         = err_q;
endmodule
